// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: single-step shift/rotate/load/clear per
// cycle, plus a multi-cycle "shift by N" operation with a start/busy/done handshake.
//
// state | meaning
// IDLE  | one step of mode per enabled cycle; start latches op and amount
// SHIFT | one step of the latched op per enabled cycle until the count runs out
// DONE  | one-cycle done pulse, Q holds, always returns to IDLE
module universal_shift_register #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    output logic [WIDTH-1:0] Q,
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_SLL   = 3'b001;
    localparam logic [2:0] M_SRL   = 3'b010;
    localparam logic [2:0] M_SRA   = 3'b011;
    localparam logic [2:0] M_ROL   = 3'b100;
    localparam logic [2:0] M_ROR   = 3'b101;
    localparam logic [2:0] M_LOAD  = 3'b110;
    localparam logic [2:0] M_CLEAR = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   q_q, q_d;

    function automatic logic [WIDTH-1:0] step_fn(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] ld,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] nxt;
        case (op)
            M_SLL:   nxt = {cur[WIDTH-2:0], sl};
            M_SRL:   nxt = {sr, cur[WIDTH-1:1]};
            M_SRA:   nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
            M_ROL:   nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
            M_ROR:   nxt = {cur[0], cur[WIDTH-1:1]};
            M_LOAD:  nxt = ld;
            M_CLEAR: nxt = '0;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= M_HOLD;
            cnt_q   <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    if (start) begin
                        op_d  = mode;
                        cnt_d = amount;
                        // Non-shift ops and zero-length shifts finish in one cycle.
                        if (mode == M_HOLD || mode == M_LOAD || mode == M_CLEAR ||
                            amount == '0) begin
                            if (mode == M_LOAD || mode == M_CLEAR) begin
                                q_d = step_fn(mode, q_q, load_data, ser_in_l, ser_in_r);
                            end
                            state_d = S_DONE;
                        end else begin
                            state_d = S_SHIFT;
                        end
                    end else begin
                        q_d = step_fn(mode, q_q, load_data, ser_in_l, ser_in_r);
                    end
                end
            end
            S_SHIFT: begin
                if (en) begin
                    q_d   = step_fn(op_q, q_q, load_data, ser_in_l, ser_in_r);
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state_q == S_SHIFT);
        done = (state_q == S_DONE);
    end

    assign Q         = q_q;
    assign ser_out_l = q_q[WIDTH-1];
    assign ser_out_r = q_q[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register: an 8-bit and a 32-bit instance
// exercised with hand-computed vectors.
module tb_universal_shift_register;

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_SLL   = 3'b001;
    localparam logic [2:0] M_SRL   = 3'b010;
    localparam logic [2:0] M_SRA   = 3'b011;
    localparam logic [2:0] M_ROL   = 3'b100;
    localparam logic [2:0] M_ROR   = 3'b101;
    localparam logic [2:0] M_LOAD  = 3'b110;
    localparam logic [2:0] M_CLEAR = 3'b111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        rst8 = 1'b1, en8 = 1'b0, start8 = 1'b0, sil8 = 1'b0, sir8 = 1'b0;
    logic [2:0]  mode8 = M_HOLD;
    logic [3:0]  amount8 = '0;
    logic [7:0]  load8 = '0;
    logic [7:0]  q8;
    logic        sol8, sor8, busy8, done8;

    logic        rst32 = 1'b1, en32 = 1'b0, start32 = 1'b0, sil32 = 1'b0, sir32 = 1'b0;
    logic [2:0]  mode32 = M_HOLD;
    logic [5:0]  amount32 = '0;
    logic [31:0] load32 = '0;
    logic [31:0] q32;
    logic        sol32, sor32, busy32, done32;

    universal_shift_register #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .en(en8), .mode(mode8), .start(start8),
        .amount(amount8), .load_data(load8), .ser_in_l(sil8), .ser_in_r(sir8),
        .Q(q8), .ser_out_l(sol8), .ser_out_r(sor8), .busy(busy8), .done(done8)
    );

    universal_shift_register #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst32), .en(en32), .mode(mode32), .start(start32),
        .amount(amount32), .load_data(load32), .ser_in_l(sil32), .ser_in_r(sir32),
        .Q(q32), .ser_out_l(sol32), .ser_out_r(sor32), .busy(busy32), .done(done32)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a start on the 8-bit instance and follows it to done (bounded).
    task automatic run8(input logic [2:0] m, input logic [3:0] amt,
                        input int stall_from, input int stall_len, input bit toggle,
                        input logic [63:0] sin,
                        output int busy_cnt, output int done_cnt, output int done_idx,
                        output logic [7:0] q_done, output logic sol_done);
        busy_cnt = 0;
        done_cnt = 0;
        done_idx = -1;
        q_done   = 'x;
        sol_done = 1'bx;
        for (int i = 0; i < 64; i++) begin
            if (i == 0) begin
                start8  = 1'b1;
                mode8   = m;
                amount8 = amt;
                en8     = 1'b1;
            end else begin
                start8 = toggle ? i[0] : 1'b0;
                mode8  = toggle ? (i[0] ? M_ROL : M_LOAD) : M_HOLD;
                en8    = !(i >= stall_from && i < stall_from + stall_len);
                sil8   = sin[i-1];
            end
            tick();
            if (busy8) busy_cnt++;
            if (done8) begin
                done_cnt++;
                done_idx = i;
                q_done   = q8;
                sol_done = sol8;
                break;
            end
        end
        start8 = 1'b0;
        mode8  = M_HOLD;
        en8    = 1'b1;
        sil8   = 1'b0;
        tick();
        if (done8) done_cnt++;
        if (busy8) busy_cnt++;
    endtask

    task automatic test_reset();
        rst8 = 1'b1; rst32 = 1'b1;
        tick();
        checks++; if (q8 !== 8'h00) begin failures++; $display("FAIL reset_q8 got=%h exp=00", q8); end
        checks++; if ({busy8, done8} !== 2'b00) begin failures++; $display("FAIL reset_flags8 got=%b exp=00", {busy8, done8}); end
        checks++; if (q32 !== 32'h0) begin failures++; $display("FAIL reset_q32 got=%h exp=0", q32); end
        rst8 = 1'b0; rst32 = 1'b0;
        en8 = 1'b1; mode8 = M_LOAD; load8 = 8'hA5;
        tick();
        checks++; if (q8 !== 8'hA5) begin failures++; $display("FAIL rst_load got=%h exp=a5", q8); end
        start8 = 1'b1; mode8 = M_SLL; amount8 = 4'd5;
        tick();
        start8 = 1'b0; mode8 = M_HOLD;
        tick();
        tick();
        checks++; if (busy8 !== 1'b1 || q8 !== 8'h94) begin failures++; $display("FAIL rst_midshift got busy=%b q=%h exp busy=1 q=94", busy8, q8); end
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        checks++; if (q8 !== 8'h00 || busy8 !== 1'b0 || done8 !== 1'b0) begin failures++; $display("FAIL rst_abort got q=%h busy=%b done=%b exp q=00 busy=0 done=0", q8, busy8, done8); end
        tick();
        checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin failures++; $display("FAIL rst_idle got busy=%b done=%b exp 0 0", busy8, done8); end
        mode8 = M_LOAD; load8 = 8'h11;
        tick();
        checks++; if (q8 !== 8'h11) begin failures++; $display("FAIL rst_after_step got=%h exp=11", q8); end
    endtask

    task automatic test_single_step();
        en8 = 1'b1; start8 = 1'b0;
        mode8 = M_LOAD; load8 = 8'h81; tick();
        checks++; if (q8 !== 8'h81 || sol8 !== 1'b1 || sor8 !== 1'b1) begin failures++; $display("FAIL ss_load got q=%h sol=%b sor=%b exp 81 1 1", q8, sol8, sor8); end
        mode8 = M_ROL; tick();
        checks++; if (q8 !== 8'h03) begin failures++; $display("FAIL ss_rol got=%h exp=03", q8); end
        mode8 = M_ROR; tick();
        checks++; if (q8 !== 8'h81) begin failures++; $display("FAIL ss_ror got=%h exp=81", q8); end
        mode8 = M_SRA; tick();
        checks++; if (q8 !== 8'hC0) begin failures++; $display("FAIL ss_sra got=%h exp=c0", q8); end
        mode8 = M_SRL; sir8 = 1'b0; tick();
        checks++; if (q8 !== 8'h60 || sol8 !== 1'b0 || sor8 !== 1'b0) begin failures++; $display("FAIL ss_srl got q=%h sol=%b sor=%b exp 60 0 0", q8, sol8, sor8); end
        mode8 = M_SLL; sil8 = 1'b1; tick();
        checks++; if (q8 !== 8'hC1) begin failures++; $display("FAIL ss_sll got=%h exp=c1", q8); end
        sil8 = 1'b0;
        mode8 = M_SRL; sir8 = 1'b1; tick();
        checks++; if (q8 !== 8'hE0) begin failures++; $display("FAIL ss_srl_in1 got=%h exp=e0", q8); end
        sir8 = 1'b0;
        en8 = 1'b0; mode8 = M_CLEAR; start8 = 1'b1; tick(); tick();
        checks++; if (q8 !== 8'hE0 || busy8 !== 1'b0 || done8 !== 1'b0) begin failures++; $display("FAIL ss_en_low got q=%h busy=%b done=%b exp e0 0 0", q8, busy8, done8); end
        start8 = 1'b0; en8 = 1'b1; tick();
        checks++; if (q8 !== 8'h00) begin failures++; $display("FAIL ss_clear got=%h exp=00", q8); end
        mode8 = M_HOLD;
    endtask

    task automatic test_multi_rotate32();
        int busy_cnt;
        int done_idx;
        logic [31:0] q_done;
        busy_cnt = 0; done_idx = -1; q_done = 'x;
        en32 = 1'b1; mode32 = M_LOAD; load32 = 32'h8000_0001;
        tick();
        checks++; if (q32 !== 32'h8000_0001) begin failures++; $display("FAIL rot32_load got=%h exp=80000001", q32); end
        for (int i = 0; i < 20; i++) begin
            start32  = (i == 0);
            mode32   = (i == 0) ? M_ROR : M_HOLD;
            amount32 = 6'd4;
            tick();
            if (busy32) busy_cnt++;
            if (done32) begin
                done_idx = i;
                q_done   = q32;
                break;
            end
        end
        start32 = 1'b0; mode32 = M_HOLD;
        checks++; if (busy_cnt !== 4) begin failures++; $display("FAIL rot32_busy got=%0d exp=4", busy_cnt); end
        checks++; if (done_idx !== 4) begin failures++; $display("FAIL rot32_done_cycle got=%0d exp=4", done_idx); end
        checks++; if (q_done !== 32'h1800_0000) begin failures++; $display("FAIL rot32_q got=%h exp=18000000", q_done); end
        tick();
        checks++; if (done32 !== 1'b0 || q32 !== 32'h1800_0000) begin failures++; $display("FAIL rot32_after got done=%b q=%h exp 0 18000000", done32, q32); end
    endtask

    task automatic test_stall_ignore();
        int bc, dc, di;
        logic [7:0] qd;
        logic sd;
        en8 = 1'b1; mode8 = M_LOAD; load8 = 8'h01; sil8 = 1'b0;
        tick();
        run8(M_SLL, 4'd3, 2, 2, 1'b1, 64'h0, bc, dc, di, qd, sd);
        checks++; if (qd !== 8'h08) begin failures++; $display("FAIL stall_q got=%h exp=08", qd); end
        checks++; if (dc !== 1) begin failures++; $display("FAIL stall_done_count got=%0d exp=1", dc); end
        checks++; if (bc !== 5) begin failures++; $display("FAIL stall_busy got=%0d exp=5", bc); end
        checks++; if (di !== 5) begin failures++; $display("FAIL stall_done_cycle got=%0d exp=5", di); end
    endtask

    task automatic test_boundaries();
        int bc, dc, di;
        logic [7:0] qd;
        logic sd;
        en8 = 1'b1; mode8 = M_LOAD; load8 = 8'h80;
        tick();
        run8(M_SRA, 4'd9, 0, 0, 1'b0, 64'h0, bc, dc, di, qd, sd);
        checks++; if (qd !== 8'hFF || bc !== 9 || di !== 9) begin failures++; $display("FAIL sra9 got q=%h busy=%0d done_at=%0d exp ff 9 9", qd, bc, di); end
        run8(M_SLL, 4'd0, 0, 0, 1'b0, 64'h0, bc, dc, di, qd, sd);
        checks++; if (qd !== 8'hFF || bc !== 0 || di !== 0 || dc !== 1) begin failures++; $display("FAIL sll0 got q=%h busy=%0d done_at=%0d dones=%0d exp ff 0 0 1", qd, bc, di, dc); end
        load8 = 8'h3C;
        run8(M_LOAD, 4'd5, 0, 0, 1'b0, 64'h0, bc, dc, di, qd, sd);
        checks++; if (qd !== 8'h3C || bc !== 0 || di !== 0 || dc !== 1) begin failures++; $display("FAIL load_start got q=%h busy=%0d done_at=%0d dones=%0d exp 3c 0 0 1", qd, bc, di, dc); end
        // start held through DONE must not relaunch and DONE must not step Q
        start8 = 1'b1; mode8 = M_CLEAR; en8 = 1'b1;
        tick();
        checks++; if (done8 !== 1'b1 || q8 !== 8'h00) begin failures++; $display("FAIL clear_start got done=%b q=%h exp 1 00", done8, q8); end
        mode8 = M_LOAD; load8 = 8'h77;
        tick();
        start8 = 1'b0; mode8 = M_HOLD;
        checks++; if (q8 !== 8'h00 || done8 !== 1'b0 || busy8 !== 1'b0) begin failures++; $display("FAIL done_ignores_start got q=%h done=%b busy=%b exp 00 0 0", q8, done8, busy8); end
        tick();
    endtask

    task automatic test_serial_in();
        int bc, dc, di;
        logic [7:0] qd;
        logic sd;
        en8 = 1'b1; mode8 = M_CLEAR;
        tick();
        // bit k of the vector is the k-th serial bit: 1,0,1,1,0,0,1,0
        run8(M_SLL, 4'd8, 0, 0, 1'b0, 64'h4D, bc, dc, di, qd, sd);
        checks++; if (qd !== 8'hB2) begin failures++; $display("FAIL serial_q got=%h exp=b2", qd); end
        checks++; if (sd !== 1'b1) begin failures++; $display("FAIL serial_out_l got=%b exp=1", sd); end
        checks++; if (bc !== 8 || di !== 8 || dc !== 1) begin failures++; $display("FAIL serial_timing got busy=%0d done_at=%0d dones=%0d exp 8 8 1", bc, di, dc); end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_multi_rotate32();
        test_stall_ignore();
        test_boundaries();
        test_serial_in();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
